// File: rtl/tlc1543_xfer_if.sv
// ============================================================================
// Module      : tlc1543_xfer_if
// Description : Bundle of request, ADC pin and result signals for the
//               TLC1543 transaction sequencer.
//               Requester side (master) drives:
//                 start, channel, eoc_rise, adc_dout
//               Sequencer side (slave) drives:
//                 adc_cs_n, adc_ioclk, adc_addr, busy, data_out,
//                 result_ch, data_valid, timeout
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tlc1543_xfer_if;
    logic       start;       // one-cycle conversion request
    logic [3:0] channel;     // address captured together with start
    logic       eoc_rise;    // rising-edge pulse of the EOC pin
    logic       adc_dout;    // ADC DATA OUT pin
    logic       adc_cs_n;    // ADC chip select
    logic       adc_ioclk;   // ADC I/O CLOCK
    logic       adc_addr;    // ADC ADDRESS pin
    logic       busy;        // transaction in progress
    logic [9:0] data_out;    // last result, MSB first received
    logic [3:0] result_ch;   // channel that data_out belongs to
    logic       data_valid;  // one-cycle pulse on data_out update
    logic       timeout;     // sticky EOC timeout flag

    modport master (
        output start, channel, eoc_rise, adc_dout,
        input  adc_cs_n, adc_ioclk, adc_addr, busy,
               data_out, result_ch, data_valid, timeout
    );

    modport slave (
        input  start, channel, eoc_rise, adc_dout,
        output adc_cs_n, adc_ioclk, adc_addr, busy,
               data_out, result_ch, data_valid, timeout
    );
endinterface

`default_nettype wire

// File: rtl/tlc1543_xfer.sv
// ============================================================================
// Module      : tlc1543_xfer
// Description : Transaction sequencer for the TLC1543 10-bit serial ADC.
//               On each accepted start it drops CS, clocks the 4-bit
//               channel address out MSB-first while clocking the previous
//               conversion result in, releases CS, waits for the EOC
//               rising-edge pulse (or a timeout) and publishes the word.
// Ports       : clk_in - system clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - tlc1543_xfer_if.slave (request, ADC pins, result)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlc1543_xfer #(
    parameter int CLK_DIV     = 25,   // clk_in cycles per I/O-clock half period (>=2)
    parameter int CS_SETUP    = 4,    // clk_in cycles from CS fall to SHIFT (>=1)
    parameter int EOC_TIMEOUT = 5000  // WAIT_EOC abort threshold (>=1)
) (
    input wire            clk_in,
    input wire            rst_n,
    tlc1543_xfer_if.slave bus
);

    // ------------------------------------------------------------------
    // Counter sizing
    // ------------------------------------------------------------------
    localparam int c_CNT_MAX = (CS_SETUP > EOC_TIMEOUT) ? CS_SETUP : EOC_TIMEOUT;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_HALF_W  = $clog2(CLK_DIV);

    localparam logic [c_CNT_W-1:0]  c_SETUP_LAST = c_CNT_W'(CS_SETUP - 1);
    // Without an EOC pulse WAIT_EOC lasts EOC_TIMEOUT+1 cycles, so DONE
    // lands EOC_TIMEOUT+1 cycles after the first cycle with CS high.
    localparam logic [c_CNT_W-1:0]  c_EOC_LAST   = c_CNT_W'(EOC_TIMEOUT);
    localparam logic [c_HALF_W-1:0] c_HALF_LAST  = c_HALF_W'(CLK_DIV - 1);
    localparam logic [3:0]          c_LAST_BIT   = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SETUP    = 3'd1,
        S_SHIFT    = 3'd2,
        S_HOLD     = 3'd3,
        S_WAIT_EOC = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;       // SETUP length / EOC timeout
    logic [c_HALF_W-1:0] r_half;      // position inside an I/O-clock half period
    logic [3:0]          r_bit;       // bit period 0..9 within SHIFT
    logic [9:0]          r_shift;     // incoming result, MSB first
    logic [3:0]          r_cur_ch;    // channel addressed by this transaction
    logic [3:0]          r_prev_ch;   // channel the ADC is returning now
    logic                r_cs_n;
    logic                r_ioclk;
    logic                r_addr;
    logic                r_busy;
    logic [9:0]          r_data_out;
    logic [3:0]          r_result_ch;
    logic                r_data_valid;
    logic                r_timeout;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_half       <= '0;
            r_bit        <= 4'd0;
            r_shift      <= 10'd0;
            r_cur_ch     <= 4'd0;
            r_prev_ch    <= 4'hF;
            r_cs_n       <= 1'b1;
            r_ioclk      <= 1'b0;
            r_addr       <= 1'b0;
            r_busy       <= 1'b0;
            r_data_out   <= 10'd0;
            r_result_ch  <= 4'hF;
            r_data_valid <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_cur_ch  <= bus.channel;
                        r_timeout <= 1'b0;
                        r_busy    <= 1'b1;
                        r_cs_n    <= 1'b0;
                        // Address MSB must already be on the pin during SETUP.
                        r_addr    <= bus.channel[3];
                        r_cnt     <= '0;
                        r_state   <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (r_cnt == c_SETUP_LAST) begin
                        r_cnt   <= '0;
                        r_half  <= '0;
                        r_bit   <= 4'd0;
                        r_ioclk <= 1'b0;
                        r_state <= S_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_SHIFT: begin
                    if (r_half == c_HALF_LAST) begin
                        r_half <= '0;
                        if (!r_ioclk) begin
                            // Rising edge of the I/O clock: capture DATA OUT.
                            r_ioclk <= 1'b1;
                            r_shift <= {r_shift[8:0], bus.adc_dout};
                        end else begin
                            // Falling edge: the ADC latched the address bit on
                            // the rise, so the next one goes out now, giving a
                            // full low phase of setup before the next rise.
                            r_ioclk <= 1'b0;
                            case (r_bit)
                                4'd0:    r_addr <= r_cur_ch[2];
                                4'd1:    r_addr <= r_cur_ch[1];
                                4'd2:    r_addr <= r_cur_ch[0];
                                default: r_addr <= 1'b0;
                            endcase
                            if (r_bit == c_LAST_BIT) begin
                                r_state <= S_HOLD;
                            end else begin
                                r_bit <= r_bit + 4'd1;
                            end
                        end
                    end else begin
                        r_half <= r_half + 1'b1;
                    end
                end

                S_HOLD: begin
                    if (r_half == c_HALF_LAST) begin
                        r_half  <= '0;
                        r_cs_n  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_WAIT_EOC;
                    end else begin
                        r_half <= r_half + 1'b1;
                    end
                end

                S_WAIT_EOC: begin
                    // DONE's outputs are registered on the way in so that
                    // data_valid is high exactly during the DONE cycle.
                    if (bus.eoc_rise || (r_cnt == c_EOC_LAST)) begin
                        if (!bus.eoc_rise) begin
                            r_timeout <= 1'b1;
                        end
                        r_data_out   <= r_shift;
                        r_result_ch  <= r_prev_ch;
                        r_prev_ch    <= r_cur_ch;
                        r_data_valid <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.adc_cs_n   = r_cs_n;
    assign bus.adc_ioclk  = r_ioclk;
    assign bus.adc_addr   = r_addr;
    assign bus.busy       = r_busy;
    assign bus.data_out   = r_data_out;
    assign bus.result_ch  = r_result_ch;
    assign bus.data_valid = r_data_valid;
    assign bus.timeout    = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_tlc1543_xfer.sv
// ============================================================================
// Module      : tb_tlc1543_xfer
// Description : Self-checking bench for tlc1543_xfer. A stimulus process
//               issues transactions and queues the expected results; a
//               monitor process models the ADC pins and compares every
//               observed event against those queues.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tlc1543_xfer;

    localparam int CLK_DIV     = 2;
    localparam int CS_SETUP    = 2;
    localparam int EOC_TIMEOUT = 50;

    localparam logic [19:0] RST_V = {1'b1, 5'b00000, 10'h000, 4'hF};

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;

    always #5 clk_in = ~clk_in;

    tlc1543_xfer_if bus();

    tlc1543_xfer #(
        .CLK_DIV     (CLK_DIV),
        .CS_SETUP    (CS_SETUP),
        .EOC_TIMEOUT (EOC_TIMEOUT)
    ) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic [9:0] data;
        logic [3:0] ch;
        logic       to;
    } exp_t;

    exp_t       sb_q[$];     // expected published results
    logic [9:0] adc_q[$];    // words the ADC model returns
    int         eoc_q[$];    // EOC delay after CS rise, 0 = never
    logic [9:0] addr_q[$];   // expected address bits at the 10 ioclk rises

    logic m_eoc  = 1'b0;     // EOC pulse from the ADC model
    logic t_eoc  = 1'b0;     // stray EOC pulse from stimulus
    logic m_dout = 1'b0;

    assign bus.eoc_rise = m_eoc | t_eoc;
    assign bus.adc_dout = m_dout;

    int         n_checks   = 0;
    int         n_errors   = 0;
    int         mon_pulses = 0;
    int         cyc        = 0;
    bit         chk_idle   = 1'b0;
    logic [3:0] m_prev_ch  = 4'hF;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [19:0] outv();
        return {bus.adc_cs_n, bus.adc_ioclk, bus.adc_addr, bus.busy,
                bus.data_valid, bus.timeout, bus.data_out, bus.result_ch};
    endfunction

    // ------------------------------------------------------------------
    // Monitor: ADC pin model plus all comparisons
    // ------------------------------------------------------------------
    initial begin : monitor
        logic       p_cs, p_clk, p_busy, p_teoc, dv_after, acc_pend;
        int         acc_cyc, exp_dv_cyc, eoc_cnt, bitn, d;
        logic [9:0] word, addr_cap;
        exp_t       e;
        p_cs = 1'b1; p_clk = 1'b0; p_busy = 1'b0; p_teoc = 1'b0;
        dv_after = 1'b0; acc_pend = 1'b0;
        acc_cyc = -1000; exp_dv_cyc = -1; eoc_cnt = 0; bitn = 0; d = 0;
        word = 10'h0; addr_cap = 10'h0;
        forever begin
            @(negedge clk_in);
            cyc++;
            if (!rst_n) begin
                chk("reset_state", outv(), RST_V);
                sb_q.delete(); adc_q.delete(); eoc_q.delete(); addr_q.delete();
                m_eoc = 1'b0; m_dout = 1'b0; eoc_cnt = 0; acc_pend = 1'b0;
                dv_after = 1'b0; acc_cyc = -1000; mon_pulses = 0;
                p_cs = 1'b1; p_clk = 1'b0; p_busy = 1'b0; p_teoc = 1'b0;
            end else begin
                if (chk_idle) chk("idle_state", outv(), RST_V);

                m_eoc = 1'b0;
                if (eoc_cnt > 0) begin
                    eoc_cnt--;
                    if (eoc_cnt == 0) begin
                        m_eoc      = 1'b1;
                        exp_dv_cyc = cyc + 1;
                    end
                end

                if (acc_pend) begin
                    chk("accept_resp", {bus.busy, bus.adc_cs_n, bus.timeout}, 3'b100);
                    acc_pend = 1'b0;
                end
                if (dv_after) begin
                    chk("dv_pulse_end", {bus.data_valid, bus.busy}, 2'b00);
                    dv_after = 1'b0;
                end
                if (p_teoc && !p_busy)
                    chk("eoc_idle_ignored", {bus.busy, bus.adc_cs_n, bus.data_valid}, 3'b010);

                if (p_cs && !bus.adc_cs_n) begin
                    chk("cs_fall_cycle", cyc, acc_cyc + 1);
                    chk("adc_word_avail", adc_q.size(), 1);
                    if (adc_q.size() != 0) word = adc_q.pop_front();
                    bitn = 0; m_dout = word[9]; mon_pulses = 0; addr_cap = 10'h0;
                end
                if (!p_clk && bus.adc_ioclk) begin
                    mon_pulses++;
                    addr_cap = {addr_cap[8:0], bus.adc_addr};
                    if (mon_pulses == 1)
                        chk("first_rise_cycle", cyc, acc_cyc + 1 + CS_SETUP + CLK_DIV);
                end
                if (p_clk && !bus.adc_ioclk) begin
                    bitn++;
                    m_dout = (bitn < 10) ? word[9 - bitn] : 1'b0;
                end
                if (!p_cs && bus.adc_cs_n) begin
                    chk("ioclk_pulses", mon_pulses, 10);
                    chk("addr_avail", addr_q.size(), 1);
                    if (addr_q.size() != 0) chk("addr_seq", addr_cap, addr_q.pop_front());
                    chk("cs_rise_cycle", cyc, acc_cyc + 1 + CS_SETUP + 21 * CLK_DIV);
                    d = 0;
                    if (eoc_q.size() != 0) d = eoc_q.pop_front();
                    if (d > 0) eoc_cnt = d;
                    else       exp_dv_cyc = cyc + EOC_TIMEOUT + 1;
                    m_dout = 1'b0;
                end

                if (bus.data_valid) begin
                    chk("dv_expected", sb_q.size(), 1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        chk("dv_data", bus.data_out, e.data);
                        chk("dv_result_ch", bus.result_ch, e.ch);
                        chk("dv_timeout", bus.timeout, e.to);
                        chk("dv_cycle", cyc, exp_dv_cyc);
                    end
                    dv_after = 1'b1;
                end

                if (bus.start && !bus.busy) begin
                    acc_pend = 1'b1;
                    acc_cyc  = cyc;
                end
                p_cs = bus.adc_cs_n; p_clk = bus.adc_ioclk;
                p_busy = bus.busy; p_teoc = t_eoc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic bail(input string nm);
        $display("FAIL %s: wait bound expired at cycle %0d", nm, cyc);
        $fatal(1);
    endtask

    task automatic do_xfer(input logic [3:0] ch, input logic [9:0] w, input int dly);
        int   guard;
        exp_t e;
        guard = 0;
        while (bus.busy !== 1'b0) begin
            tick();
            guard++;
            if (guard > 1000) bail("busy_wait");
        end
        e.data = w; e.ch = m_prev_ch; e.to = (dly == 0);
        adc_q.push_back(w);
        eoc_q.push_back(dly);
        addr_q.push_back({ch, 6'b000000});
        sb_q.push_back(e);
        m_prev_ch   = ch;
        bus.start   = 1'b1;
        bus.channel = ch;
        tick();
        bus.start   = 1'b0;
        bus.channel = 4'($urandom);
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (sb_q.size() != 0 || bus.busy !== 1'b0) begin
            tick();
            guard++;
            if (guard > 1000) bail("done_wait");
        end
    endtask

    task automatic wait_pulses(input int n);
        int guard;
        guard = 0;
        do begin
            tick();
            guard++;
            if (guard > 1000) bail("pulse_wait");
        end while (mon_pulses < n);
    endtask

    task automatic pulse_start(input logic [3:0] ch);
        bus.start   = 1'b1;
        bus.channel = ch;
        tick();
        bus.start   = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : stim
        int guard;
        bus.start   = 1'b0;
        bus.channel = 4'h0;
        rst_n       = 1'b0;

        // Reset, with a start request that must be ignored
        repeat (3) tick();
        pulse_start(4'h5);
        repeat (2) tick();
        rst_n    = 1'b1;
        chk_idle = 1'b1;
        repeat (100) tick();
        chk_idle = 1'b0;

        // Directed single transaction
        do_xfer(4'b1010, 10'h2D5, 20);
        wait_done();

        // Back-to-back with ignored starts while busy
        do_xfer(4'd3, 10'($urandom), int'($urandom_range(5, 30)));
        wait_pulses(3);
        pulse_start(4'hC);
        guard = 0;
        while (bus.adc_cs_n !== 1'b1) begin
            tick();
            guard++;
            if (guard > 1000) bail("cs_rise_wait");
        end
        if (bus.busy === 1'b1) pulse_start(4'hE);
        do_xfer(4'd7, 10'($urandom), int'($urandom_range(1, 30)));
        wait_done();

        // EOC timeout, then a start that clears the flag
        do_xfer(4'($urandom), 10'($urandom), 0);
        wait_done();
        do_xfer(4'($urandom), 10'($urandom), 10);
        wait_done();

        // Stray EOC pulses during SHIFT and during IDLE
        do_xfer(4'($urandom), 10'($urandom), 15);
        wait_pulses(4);
        t_eoc = 1'b1; tick(); t_eoc = 1'b0;
        wait_done();
        repeat (3) tick();
        t_eoc = 1'b1; tick(); t_eoc = 1'b0;
        repeat (3) tick();

        // Randomized traffic, occasionally timing out
        for (int i = 0; i < 20; i++) begin
            do_xfer(4'($urandom), 10'($urandom),
                    ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40)));
        end
        wait_done();

        // Reset in the middle of SHIFT bit 5
        do_xfer(4'($urandom), 10'($urandom), 10);
        wait_pulses(6);
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n     = 1'b1;
        m_prev_ch = 4'hF;
        repeat (5) tick();
        do_xfer(4'($urandom), 10'($urandom), 12);
        wait_done();

        repeat (5) tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
